// File: rtl/rst_pkg.sv
// Shared definitions for the system reset controller: one-hot FSM encoding,
// cause register bit positions and counter width.
package rst_pkg;

  // Shared HOLD/STAGE counter width; wide enough for the largest hold time.
  localparam int RST_CNT_W = 24;

  // Bit positions of the one-hot state flops.
  localparam int ST_HOLD_BIT  = 0;
  localparam int ST_STAGE_BIT = 1;
  localparam int ST_RUN_BIT   = 2;

  // One-hot sequencing states.
  typedef enum logic [2:0] {
    ST_HOLD  = 3'b001,
    ST_STAGE = 3'b010,
    ST_RUN   = 3'b100
  } rst_state_e;

  // Bit positions inside the 5-bit sticky cause register.
  localparam int CAUSE_SW  = 0;
  localparam int CAUSE_WD  = 1;
  localparam int CAUSE_BTN = 2;
  localparam int CAUSE_CLK = 3;
  localparam int CAUSE_POR = 4;
  localparam int CAUSE_W   = 5;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a single asynchronous level.
// Both flops clear to 0 on reset, so the synchronised level reads low
// until the input has been seen high for two clock edges.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/rst_ctrl.sv
// System reset controller: arbitrates clock-loss, button, watchdog and
// software reset sources, records the last cause, and releases the
// peripheral reset first and the CPU reset a fixed number of cycles later.
module rst_ctrl
  import rst_pkg::*;
#(
  parameter logic [RST_CNT_W-1:0] HOLD_CYC  = 24'h0FFFFF,
  parameter logic [7:0]           STAGE_CYC = 8'd16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_ok,
  input  logic               btn_rst,
  input  logic               wd_trig,
  input  logic               sw_rst,
  input  logic               cause_clr,
  output logic               rst_periph,
  output logic               rst_cpu,
  output logic               rst_cpu_n,
  output logic               busy,
  output logic [CAUSE_W-1:0] cause
);

  logic                 clk_ok_s;
  logic                 clk_lost_s;
  logic                 level_req_s;
  logic                 any_req_s;
  logic [CAUSE_W-1:0]   req_cause_s;
  logic                 cause_upd_s;
  logic [RST_CNT_W-1:0] hold_last_s;
  logic [RST_CNT_W-1:0] stage_last_s;

  rst_state_e           state_r;
  rst_state_e           state_nxt_s;
  logic [RST_CNT_W-1:0] cnt_r;
  logic [RST_CNT_W-1:0] cnt_nxt_s;
  logic [CAUSE_W-1:0]   cause_r;

  // PLL lock crosses into the clk domain here; it reads "lost" until seen.
  sync2 u_clk_ok_sync (
    .clk (clk),
    .rst (rst),
    .d   (clk_ok),
    .q   (clk_ok_s)
  );

  assign clk_lost_s   = ~clk_ok_s;
  assign level_req_s  = clk_lost_s | btn_rst;
  assign any_req_s    = level_req_s | wd_trig | sw_rst;
  assign hold_last_s  = HOLD_CYC - 24'd1;
  assign stage_last_s = {16'd0, STAGE_CYC - 8'd1};

  // Priority encoder: one-hot of the highest-priority active request.
  always_comb begin
    req_cause_s = 5'b00000;
    if (clk_lost_s) begin
      req_cause_s[CAUSE_CLK] = 1'b1;
    end else if (btn_rst) begin
      req_cause_s[CAUSE_BTN] = 1'b1;
    end else if (wd_trig) begin
      req_cause_s[CAUSE_WD] = 1'b1;
    end else if (sw_rst) begin
      req_cause_s[CAUSE_SW] = 1'b1;
    end else begin
      req_cause_s = 5'b00000;
    end
  end

  // Next-state and counter logic for the HOLD -> STAGE -> RUN sequence.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cause_upd_s = 1'b0;
    case (state_r)
      ST_HOLD: begin
        // Pulse requests are ignored here: resets are already asserted.
        if (level_req_s) begin
          cnt_nxt_s = 24'd0;
        end else if (cnt_r == hold_last_s) begin
          state_nxt_s = ST_STAGE;
          cnt_nxt_s   = 24'd0;
        end else begin
          cnt_nxt_s = cnt_r + 24'd1;
        end
      end
      ST_STAGE: begin
        if (any_req_s) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = 24'd0;
          cause_upd_s = 1'b1;
        end else if (cnt_r == stage_last_s) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = 24'd0;
        end else begin
          cnt_nxt_s = cnt_r + 24'd1;
        end
      end
      ST_RUN: begin
        cnt_nxt_s = 24'd0;
        if (any_req_s) begin
          state_nxt_s = ST_HOLD;
          cause_upd_s = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        // A corrupted state vector falls back to full reset.
        state_nxt_s = ST_HOLD;
        cnt_nxt_s   = 24'd0;
      end
    endcase
  end

  // State and shared counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_HOLD;
      cnt_r   <= 24'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Sticky cause register: a new cause overwrites, and beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_r <= 5'b10000;
    end else if (cause_upd_s) begin
      cause_r <= req_cause_s;
    end else if (cause_clr) begin
      cause_r <= 5'b00000;
    end else begin
      cause_r <= cause_r;
    end
  end

  // Outputs come straight off the state flops, no input-to-output path.
  // Any state other than RUN keeps the CPU in reset.
  assign rst_periph = state_r[ST_HOLD_BIT];
  assign rst_cpu    = ~state_r[ST_RUN_BIT];
  assign rst_cpu_n  = state_r[ST_RUN_BIT];
  assign busy       = ~state_r[ST_RUN_BIT];
  assign cause      = cause_r;

endmodule

// File: tb/tb_rst_ctrl.sv
// Self-checking bench for rst_ctrl with HOLD_CYC=8, STAGE_CYC=4.
// Reference model: a "cycles since the sequence last restarted" count;
// the peripheral reset is held while that count is below HOLD, the CPU
// reset while it is below HOLD+STAGE.
module tb_rst_ctrl;

  localparam int H = 8;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_ok;
  logic       btn_rst;
  logic       wd_trig;
  logic       sw_rst;
  logic       cause_clr;
  logic       rst_periph;
  logic       rst_cpu;
  logic       rst_cpu_n;
  logic       busy;
  logic [4:0] cause;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int         since_m;
  logic [4:0] cause_m;
  logic       ok_prev1_m;   // clk_ok sampled one edge ago
  logic       ok_prev2_m;   // clk_ok sampled two edges ago

  rst_ctrl #(
    .HOLD_CYC  (24'd8),
    .STAGE_CYC (8'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_ok     (clk_ok),
    .btn_rst    (btn_rst),
    .wd_trig    (wd_trig),
    .sw_rst     (sw_rst),
    .cause_clr  (cause_clr),
    .rst_periph (rst_periph),
    .rst_cpu    (rst_cpu),
    .rst_cpu_n  (rst_cpu_n),
    .busy       (busy),
    .cause      (cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_por();
    since_m    = 0;
    cause_m    = 5'b10000;
    ok_prev1_m = 1'b0;
    ok_prev2_m = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge();
    logic       lost;
    logic       lvl;
    logic       pulse;
    logic       releasing;
    logic [4:0] c;
    lost       = ~ok_prev2_m;
    ok_prev2_m = ok_prev1_m;
    ok_prev1_m = clk_ok;
    lvl        = lost | btn_rst;
    pulse      = wd_trig | sw_rst;
    releasing  = (since_m >= H);
    c = lost ? 5'b01000 : btn_rst ? 5'b00100 : wd_trig ? 5'b00010 : sw_rst ? 5'b00001 : 5'b00000;
    if (releasing && (lvl || pulse)) cause_m = c;
    else if (cause_clr) cause_m = 5'b00000;
    if (lvl || (releasing && pulse)) since_m = 0;
    else if (since_m < H + S) since_m++;
  endtask

  task automatic check_outputs();
    check("rst_periph", rst_periph, (since_m < H));
    check("rst_cpu", rst_cpu, (since_m < H + S));
    check("rst_cpu_n", rst_cpu_n, !(since_m < H + S));
    check("busy", busy, (since_m < H + S));
    check("cause", cause, cause_m);
  endtask

  // One clock cycle with the given pulse inputs.
  task automatic tick(input logic w, input logic s, input logic c);
    wd_trig   = w;
    sw_rst    = s;
    cause_clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    wd_trig   = 1'b0;
    sw_rst    = 1'b0;
    cause_clr = 1'b0;
  endtask

  // Idle until the CPU is released (bounded); check both release times.
  task automatic run_idle(input string tag, input int exp_p, input int exp_c);
    int tp;
    int tc;
    tp = -1;
    tc = -1;
    for (int i = 1; i <= 60; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (tp < 0 && rst_periph == 1'b0) tp = i;
      if (tc < 0 && rst_cpu == 1'b0) begin
        tc = i;
        break;
      end
    end
    check({tag, "_periph_fall"}, tp, exp_p);
    check({tag, "_cpu_fall"}, tc, exp_c);
  endtask

  // Async reset pulse between edges; effect checked before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_async_periph"}, rst_periph, 1'b1);
    check({tag, "_async_cpu"}, rst_cpu, 1'b1);
    check({tag, "_async_cause"}, cause, 5'b10000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_por();
  endtask

  initial begin
    rst       = 1'b1;
    clk_ok    = 1'b1;
    btn_rst   = 1'b0;
    wd_trig   = 1'b0;
    sw_rst    = 1'b0;
    cause_clr = 1'b0;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    check("por_periph", rst_periph, 1'b1);
    check("por_cpu", rst_cpu, 1'b1);
    check("por_cpu_n", rst_cpu_n, 1'b0);
    check("por_busy", busy, 1'b1);
    check("por_cause", cause, 5'b10000);
    rst = 1'b0;
    model_por();
    run_idle("por", 10, 14);
    check("por_cause_after", cause, 5'b10000);
    tick(1'b0, 1'b0, 1'b0);
    check("por_busy_after", busy, 1'b0);

    // Watchdog in RUN
    tick(1'b1, 1'b0, 1'b0);
    check("wd_periph", rst_periph, 1'b1);
    check("wd_cpu", rst_cpu, 1'b1);
    check("wd_cause", cause, 5'b00010);
    run_idle("wd", 8, 12);

    // Simultaneous software and watchdog requests
    tick(1'b1, 1'b1, 1'b0);
    check("wd_sw_cause", cause, 5'b00010);
    run_idle("wd_sw", 8, 12);

    // Button pressed in RUN and held for 20 cycles
    btn_rst = 1'b1;
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0);
    btn_rst = 1'b0;
    check("btn_cause", cause, 5'b00100);
    run_idle("btn", 8, 12);

    // Software request in STAGE when the stage counter reads 2
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < H; i++) tick(1'b0, 1'b0, 1'b0);
    check("stage_entered", rst_periph, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("stage_sw_periph", rst_periph, 1'b1);
    check("stage_sw_cause", cause, 5'b00001);
    run_idle("stage_sw", 8, 12);

    // Clear alone, then clear colliding with a software request
    tick(1'b0, 1'b0, 1'b1);
    check("clr_cause", cause, 5'b00000);
    tick(1'b0, 1'b1, 1'b1);
    check("clr_sw_cause", cause, 5'b00001);
    run_idle("clr_sw", 8, 12);

    // Clock lock lost for one cycle in RUN
    clk_ok = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    clk_ok = 1'b1;
    check("clk_drop_e1", rst_periph, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("clk_drop_e2", rst_periph, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("clk_drop_e3", rst_periph, 1'b1);
    check("clk_drop_cause", cause, 5'b01000);
    run_idle("clk_drop", 8, 12);

    // Async reset in the middle of STAGE
    tick(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < H + 1; i++) tick(1'b0, 1'b0, 1'b0);
    check("mid_stage", rst_cpu & ~rst_periph, 1'b1);
    async_reset("mid_stage");
    run_idle("mid_stage_rst", 10, 14);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999) < 3) begin
        async_reset("rand");
      end else begin
        clk_ok = ($urandom_range(99) >= 3);
        if (btn_rst) btn_rst = ($urandom_range(99) < 80);
        else         btn_rst = ($urandom_range(99) < 2);
        tick(($urandom_range(99) < 3), ($urandom_range(99) < 3), ($urandom_range(99) < 4));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
